mega_ram_dma: RTL



---
 rtl/mega_dma_pkg.sv | 16 +
 rtl/mega_ram.sv | 27 ++
 rtl/mega_ram_dma.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mega_dma_pkg.sv
// rtl/mega_dma_pkg.sv - shared state encoding and mode constants for the RAM block-copy/fill engine
package mega_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR      = 3'd4,
    ST_DONE    = 3'd5
  } dma_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mega_ram.sv
// rtl/mega_ram.sv - single-port data RAM with 1-cycle registered read
// Read data is presented only in the cycle after a cs&re sample; otherwise the output gate is closed (0).
module mega_ram #(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_cs,
  input  logic                      i_we,
  input  logic                      i_re,
  input  logic [ADDR_BUS_WIDTH-1:0] i_a,
  input  logic [DATA_BUS_WIDTH-1:0] i_d,
  output logic [DATA_BUS_WIDTH-1:0] o_d
);

  logic [DATA_BUS_WIDTH-1:0] r_mem [0:(2**ADDR_BUS_WIDTH)-1];
  logic [DATA_BUS_WIDTH-1:0] r_dout;

  always_ff @(posedge i_clk) begin
    if (i_cs && i_we) r_mem[i_a] <= i_d;
    if (i_cs && i_re) r_dout <= r_mem[i_a];
    else              r_dout <= '0;
  end

  assign o_d = r_dout;

endmodule

// File: rtl/mega_ram_dma.sv
// rtl/mega_ram_dma.sv - bus-initiator block-copy / block-fill engine for the single-port data RAM
// Strobes decode from state only; ram_a/ram_wdat hold their last value while the strobes are idle.
module mega_ram_dma
  import mega_dma_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int LEN_WIDTH      = 13
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic [ADDR_BUS_WIDTH-1:0] i_src,
  input  logic [ADDR_BUS_WIDTH-1:0] i_dst,
  input  logic [LEN_WIDTH-1:0]      i_len,
  input  logic [DATA_BUS_WIDTH-1:0] i_fill_val,
  input  logic                      i_abort,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_bus_req,
  input  logic                      i_bus_gnt,
  output logic                      o_ram_cs,
  output logic                      o_ram_we,
  output logic                      o_ram_re,
  output logic [ADDR_BUS_WIDTH-1:0] o_ram_a,
  output logic [DATA_BUS_WIDTH-1:0] o_ram_wdat,
  input  logic [DATA_BUS_WIDTH-1:0] i_ram_rdat
);

  dma_state_t r_state, w_next;

  logic [ADDR_BUS_WIDTH-1:0] r_src, r_dst, r_a_hold;
  logic [LEN_WIDTH-1:0]      r_rem;
  logic                      r_mode;
  logic [DATA_BUS_WIDTH-1:0] r_fill, r_buf, r_wdat_hold;
  dma_state_t                w_xfer_state;

  assign w_xfer_state = (r_mode == MODE_FILL) ? ST_WR : ST_RD_ADDR;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = (i_len == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (i_bus_gnt) w_next = w_xfer_state;
      end
      ST_RD_ADDR: w_next = ST_RD_DATA;
      ST_RD_DATA: w_next = ST_WR;
      ST_WR: begin
        if (r_rem == LEN_WIDTH'(1)) w_next = ST_DONE;
        else if (!i_bus_gnt)        w_next = ST_REQ;
        else                        w_next = w_xfer_state;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (i_abort && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  always_comb begin
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_bus_req  = 1'b0;
    o_ram_cs   = 1'b0;
    o_ram_we   = 1'b0;
    o_ram_re   = 1'b0;
    o_ram_a    = r_a_hold;
    o_ram_wdat = r_wdat_hold;
    case (r_state)
      ST_REQ: begin
        o_busy    = 1'b1;
        o_bus_req = 1'b1;
      end
      ST_RD_ADDR, ST_RD_DATA: begin
        o_busy    = 1'b1;
        o_bus_req = 1'b1;
        o_ram_cs  = 1'b1;
        o_ram_re  = 1'b1;
        o_ram_a   = r_src;
      end
      ST_WR: begin
        o_busy     = 1'b1;
        o_bus_req  = 1'b1;
        o_ram_cs   = 1'b1;
        o_ram_we   = 1'b1;
        o_ram_a    = r_dst;
        o_ram_wdat = (r_mode == MODE_FILL) ? r_fill : r_buf;
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath; an abort cycle does not advance the counters since the FSM returns to IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_rem       <= '0;
      r_mode      <= MODE_COPY;
      r_fill      <= '0;
      r_buf       <= '0;
      r_a_hold    <= '0;
      r_wdat_hold <= '0;
    end else begin
      r_a_hold    <= o_ram_a;
      r_wdat_hold <= o_ram_wdat;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_src  <= i_src;
            r_dst  <= i_dst;
            r_rem  <= i_len;
            r_mode <= i_mode;
            r_fill <= i_fill_val;
          end
        end
        ST_RD_DATA: begin
          if (!i_abort) r_buf <= i_ram_rdat;
        end
        ST_WR: begin
          if (!i_abort) begin
            r_dst <= r_dst + ADDR_BUS_WIDTH'(1);
            r_rem <= r_rem - LEN_WIDTH'(1);
            if (r_mode == MODE_COPY) r_src <= r_src + ADDR_BUS_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
